prog_freq_div: RTL and testbench
================================

// Module: prog_freq_div
// PURPOSE
//   Programmable integer clock-enable divider: successor to the fixed /2,/4,/8 toggle chain.
//   Divides CLK by a runtime divisor N (1..2^CNT_W-1), producing a one-cycle TICK enable,
//   a registered near-50% square wave CLK_OUT, and NUM_TAPS binary taps at CLK/(2N)..CLK/(2^NUM_TAPS*N).
//   All outputs are single-domain flops on CLK; downstream logic uses them as enables, never as clocks.
// PARAMETERS
//   CNT_W     8  width of divisor and internal counter
//   DEF_DIV   2  divisor after reset; legal range 1..2^CNT_W-1
//   NUM_TAPS  3  number of binary tap outputs, >=1
// PORTS
//   CLK       in   1         single clock, rising edge
//   RST_N     in   1         synchronous reset, active low
//   EN        in   1         count enable, sampled each edge
//   DIV_VAL   in   CNT_W     new divisor value
//   DIV_LOAD  in   1         request to load DIV_VAL (single-cycle strobe)
//   BUSY      out  1         a loaded divisor is pending, not yet applied
//   DIV_ERR   out  1         one-cycle pulse: DIV_LOAD with DIV_VAL==0 rejected
//   TICK      out  1         one-cycle pulse per N counted cycles
//   CLK_OUT   out  1         square wave, period N, high floor(N/2) cycles
//   TAP       out  NUM_TAPS  TAP[k] toggles, period 2^(k+1)*N cycles
// BEHAVIOUR
//   Clock is CLK; reset is synchronous and active-low (RST_N), sampled only on the rising edge of CLK.
//   Reset (RST_N=0 at an edge): cnt=0, div=DEF_DIV, pending cleared; BUSY, DIV_ERR, TICK, CLK_OUT, TAP all 0.
//     Reset mid-operation aborts the current period and discards any pending divisor.
//   Counter: on each edge with EN=1, cnt goes to 0 if cnt==div-1 (a "wrap"), else cnt+1. With EN=0, cnt holds.
//   TICK <= EN & (cnt==div-1). TICK is high exactly in the cycle after a wrap edge and is never high on consecutive
//     cycles unless div==1, in which case TICK is continuously high while EN=1.
//   CLK_OUT <= (cnt_next < (div_next>>1)), evaluated every edge out of reset.
//     N=1 -> CLK_OUT constant 0. Odd N -> high floor(N/2) cycles, low ceil(N/2) cycles.
//     The first high phase after reset or a divisor change is one cycle shorter (cnt leaves 0 on the first edge).
//   TAP: on a wrap edge, TAP[0] toggles. TAP[k] toggles iff TAP[k-1:0] are all 1 (synchronous binary count).
//     No toggle occurs without a wrap; TAP holds while EN=0.
//   Divisor load: DIV_LOAD=1 with DIV_VAL!=0 writes pend=DIV_VAL and sets BUSY=1.
//     A second load before apply overwrites pend (last wins).
//     DIV_LOAD=1 with DIV_VAL==0 changes no state and pulses DIV_ERR for 1 cycle.
//   Apply (glitch-free), evaluated at the same edge:
//     (a) at a wrap edge with pend valid: div<=pend, BUSY<=0;
//     (b) at any edge with EN=0 and pend valid: div<=pend, cnt<=0, BUSY<=0;
//     (c) a DIV_LOAD arriving on a wrap or EN=0 edge: DIV_VAL is applied directly that edge and BUSY stays 0.
//   The divisor never changes mid-period while EN=1; the period in progress completes with the old N.
//   Loading the currently active N is legal: it is applied as normal, with no visible change.
//   Width: cnt and div are CNT_W bits unsigned; cnt==div-1 is compared at CNT_W bits (div>=1, so no underflow).
// TESTING
//   1 Reset: RST_N=0 for 3 edges with EN=1 -> all outputs 0; after release, TICK first high 2 cycles later (DEF_DIV=2).
//   2 N=5, EN=1 for 40 cycles -> TICK every 5 cycles; CLK_OUT steady 2 high/3 low; TAP[0] period 10, TAP[2] period 40.
//   3 N=4 running; load DIV_VAL=7 at cnt=1 -> BUSY=1 for 3 cycles; the next TICK comes 3 cycles later, then every 7.
//   4 DIV_LOAD with DIV_VAL=0 -> DIV_ERR pulses 1 cycle; div, cnt, BUSY unchanged.
//   5 EN=0 for 6 cycles at cnt=2 (N=4) -> cnt, TICK=0, TAP hold; a load of 3 during EN=0 applies next edge with cnt=0.
//   6 N=1 -> TICK held 1, CLK_OUT held 0, TAP[0] toggles every cycle; RST_N=0 mid-run -> all cleared next edge.

Source files
------------

// File: rtl/prog_freq_div.sv
// ============================================================================
// Module  : prog_freq_div
// Purpose : Programmable integer clock-enable divider with tick, square wave
//           and binary tap outputs; divisor changes take effect glitch-free.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_freq_div #(
  parameter int CNT_W    = 8,
  parameter int DEF_DIV  = 2,
  parameter int NUM_TAPS = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [CNT_W-1:0]    DIV_VAL,
  input  logic                DIV_LOAD,
  output logic                BUSY,
  output logic                DIV_ERR,
  output logic                TICK,
  output logic                CLK_OUT,
  output logic [NUM_TAPS-1:0] TAP
);

  localparam logic [CNT_W-1:0] DEF_DIV_V = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] pend;

  logic             wrap;
  logic             load_ok;
  logic             boundary;
  logic             apply_new;
  logic             apply_pend;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] cnt_nxt;

  // A divisor may only change where no period is in flight: at a wrap or while paused.
  always_comb begin
    wrap       = EN && (cnt == div - ONE);
    load_ok    = DIV_LOAD && (DIV_VAL != '0);
    boundary   = wrap || !EN;
    apply_new  = load_ok && boundary;
    apply_pend = BUSY && boundary && !apply_new;

    div_nxt = div;
    if (apply_new) begin
      div_nxt = DIV_VAL;
    end else if (apply_pend) begin
      div_nxt = pend;
    end

    cnt_nxt = cnt;
    if (EN) begin
      cnt_nxt = wrap ? '0 : cnt + ONE;
    end else if (apply_new || apply_pend) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt     <= '0;
      div     <= DEF_DIV_V;
      pend    <= '0;
      BUSY    <= 1'b0;
      DIV_ERR <= 1'b0;
      TICK    <= 1'b0;
      CLK_OUT <= 1'b0;
      TAP     <= '0;
    end else begin
      cnt     <= cnt_nxt;
      div     <= div_nxt;
      DIV_ERR <= DIV_LOAD && (DIV_VAL == '0);
      TICK    <= wrap;
      CLK_OUT <= (cnt_nxt < (div_nxt >> 1));
      if (apply_new || apply_pend) begin
        BUSY <= 1'b0;
      end else if (load_ok) begin
        pend <= DIV_VAL;
        BUSY <= 1'b1;
      end
      // Binary increment gives TAP[k] toggling when all lower taps are 1.
      if (wrap) begin
        TAP <= TAP + NUM_TAPS'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prog_freq_div.sv
// ============================================================================
// Module  : tb_prog_freq_div
// Purpose : Self-checking bench for prog_freq_div (table + scoreboard + corners).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_freq_div;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] div_val = 8'd0;
  logic       div_load = 1'b0;
  logic       busy, div_err, tick, clk_out;
  logic [2:0] tap;

  always #5 clk = ~clk;

  prog_freq_div #(.CNT_W(8), .DEF_DIV(2), .NUM_TAPS(3)) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIV_VAL(div_val), .DIV_LOAD(div_load),
    .BUSY(busy), .DIV_ERR(div_err), .TICK(tick), .CLK_OUT(clk_out), .TAP(tap)
  );

  typedef struct {
    logic       tick;
    logic       clk_out;
    logic [2:0] tap;
    logic       busy;
    logic       err;
  } exp_t;

  typedef struct {
    logic       rstn;
    logic       en;
    logic       load;
    logic [7:0] val;
    exp_t       e;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state
  int   m_cnt, m_div, m_pend, m_tap;
  logic m_busy;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one edge, predict it with the model, then compare the DUT after the edge.
  task automatic step(input logic rn, input logic e, input logic ld, input logic [7:0] v);
    exp_t x;
    int   ncnt, ndiv;
    logic wrp, bnd, good, applied;
    @(negedge clk);
    rst_n = rn; en = e; div_load = ld; div_val = v;
    if (!rn) begin
      m_cnt = 0; m_div = 2; m_pend = 0; m_busy = 1'b0; m_tap = 0;
      x = '{tick: 1'b0, clk_out: 1'b0, tap: 3'd0, busy: 1'b0, err: 1'b0};
    end else begin
      wrp  = e && (m_cnt == m_div - 1);
      good = ld && (v != 0);
      bnd  = wrp || !e;
      applied = 1'b0;
      ndiv = m_div;
      if (good && bnd) begin
        ndiv = v; applied = 1'b1;
      end else if (m_busy && bnd) begin
        ndiv = m_pend; applied = 1'b1;
      end else if (good) begin
        m_pend = v;
      end
      if (applied) m_busy = 1'b0;
      else if (good) m_busy = 1'b1;
      if (e) ncnt = wrp ? 0 : m_cnt + 1;
      else   ncnt = applied ? 0 : m_cnt;
      if (wrp) m_tap = (m_tap + 1) % 8;
      m_cnt = ncnt; m_div = ndiv;
      x.tick = wrp; x.clk_out = (ncnt < (ndiv / 2)); x.tap = 3'(m_tap);
      x.busy = m_busy; x.err = ld && (v == 0);
    end
    q.push_back(x);
    @(posedge clk); #1;
    if (q.size() == 0) begin
      chk("sb_underflow", 0, 1);
    end else begin
      x = q.pop_front();
      chk("sb_tick", int'(tick), int'(x.tick));
      chk("sb_clk_out", int'(clk_out), int'(x.clk_out));
      chk("sb_tap", int'(tap), int'(x.tap));
      chk("sb_busy", int'(busy), int'(x.busy));
      chk("sb_div_err", int'(div_err), int'(x.err));
    end
  endtask

  vec_t tbl[13];

  task automatic set_row(input int i, input logic rn, input logic e, input logic ld,
                         input logic [7:0] v, input logic tk, input logic co,
                         input logic [2:0] tp, input logic b, input logic er);
    tbl[i].rstn = rn; tbl[i].en = e; tbl[i].load = ld; tbl[i].val = v;
    tbl[i].e.tick = tk; tbl[i].e.clk_out = co; tbl[i].e.tap = tp;
    tbl[i].e.busy = b; tbl[i].e.err = er;
  endtask

  initial begin
    int n_tick, n_high, t0_tog, t2_tog, gap_bad, last_tick, nb, first_at;
    logic [2:0] prev_tap;

    //          rn en ld val  tick clk tap busy err
    set_row(0,  0, 1, 0, 0,   0, 0, 0, 0, 0);
    set_row(1,  0, 1, 0, 0,   0, 0, 0, 0, 0);
    set_row(2,  0, 1, 0, 0,   0, 0, 0, 0, 0);
    set_row(3,  1, 1, 0, 0,   0, 0, 0, 0, 0);
    set_row(4,  1, 1, 0, 0,   1, 1, 1, 0, 0);
    set_row(5,  1, 1, 0, 0,   0, 0, 1, 0, 0);
    set_row(6,  1, 1, 0, 0,   1, 1, 2, 0, 0);
    set_row(7,  1, 1, 1, 0,   0, 0, 2, 0, 1);
    set_row(8,  1, 0, 0, 0,   0, 0, 2, 0, 0);
    set_row(9,  1, 0, 1, 3,   0, 1, 2, 0, 0);
    set_row(10, 1, 1, 0, 0,   0, 0, 2, 0, 0);
    set_row(11, 1, 1, 0, 0,   0, 0, 2, 0, 0);
    set_row(12, 1, 1, 0, 0,   1, 1, 3, 0, 0);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rstn, tbl[i].en, tbl[i].load, tbl[i].val);
      chk($sformatf("tbl%0d_tick", i), int'(tick), int'(tbl[i].e.tick));
      chk($sformatf("tbl%0d_clk_out", i), int'(clk_out), int'(tbl[i].e.clk_out));
      chk($sformatf("tbl%0d_tap", i), int'(tap), int'(tbl[i].e.tap));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].e.busy));
      chk($sformatf("tbl%0d_err", i), int'(div_err), int'(tbl[i].e.err));
    end

    // N=5 for 40 cycles
    step(1, 0, 1, 8'd5);
    n_tick = 0; n_high = 0; t0_tog = 0; t2_tog = 0; gap_bad = 0; last_tick = -1;
    prev_tap = tap;
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 0, 0);
      if (tick) begin
        if (last_tick >= 0 && i - last_tick != 5) gap_bad++;
        last_tick = i; n_tick++;
      end
      if (clk_out) n_high++;
      if (tap[0] != prev_tap[0]) t0_tog++;
      if (tap[2] != prev_tap[2]) t2_tog++;
      prev_tap = tap;
    end
    chk("n5_ticks", n_tick, 8);
    chk("n5_tick_gap", gap_bad, 0);
    chk("n5_clk_high", n_high, 16);
    chk("n5_tap0_toggles", t0_tog, 8);
    chk("n5_tap2_toggles", t2_tog, 2);

    // N=4 running, reload 7 mid-period
    step(1, 0, 1, 8'd4);
    step(1, 1, 1, 8'd7);
    nb = busy ? 1 : 0; first_at = -1;
    for (int i = 1; i <= 12 && first_at < 0; i++) begin
      step(1, 1, 0, 0);
      if (busy) nb++;
      if (tick) first_at = i;
    end
    chk("reload_busy_cycles", nb, 3);
    chk("reload_first_tick", first_at, 3);
    first_at = -1;
    for (int i = 1; i <= 12 && first_at < 0; i++) begin
      step(1, 1, 0, 0);
      if (tick) first_at = i;
    end
    chk("reload_new_period", first_at, 7);

    // Pause at cnt=2 with N=4, then load 3 while paused
    step(1, 0, 1, 8'd4);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    prev_tap = tap; gap_bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0);
      if (tick || tap != prev_tap) gap_bad++;
    end
    chk("pause_hold", gap_bad, 0);
    step(1, 0, 1, 8'd3);
    chk("pause_load_busy", int'(busy), 0);
    first_at = -1;
    for (int i = 1; i <= 8 && first_at < 0; i++) begin
      step(1, 1, 0, 0);
      if (tick) first_at = i;
    end
    chk("pause_load_first_tick", first_at, 3);

    // N=1, then reset mid-run
    step(1, 0, 1, 8'd1);
    gap_bad = 0;
    for (int i = 0; i < 10; i++) begin
      prev_tap = tap;
      step(1, 1, 0, 0);
      if (!tick || clk_out || tap[0] == prev_tap[0]) gap_bad++;
    end
    chk("n1_behaviour", gap_bad, 0);
    step(0, 1, 0, 0);
    chk("n1_reset_clear", int'({tick, clk_out, tap, busy, div_err}), 0);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 9) == 0), 8'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
